stream_check_arbiter: RTL and testbench
=======================================

STREAM_CHECK_ARBITER -- requirements
Module: stream_check_arbiter

Interface
REQ-001 The module SHALL have parameter DATA_WIDTH, default 32, meaning the width of each requester data word and of the checker data port.
REQ-002 The module SHALL have parameter NUM_REQ, default 4, meaning the number of requesters; the legal range is 2..8.
REQ-003 The module SHALL have parameter TIMEOUT, default 1024, meaning the number of idle RUN cycles before the watchdog fires; the legal range is 1..65535.
REQ-004 The module SHALL have one clock and an asynchronous, active-high reset: ports clk and reset.
REQ-005 clk  input  1  is the sole clock; all state SHALL update on its rising edge.
REQ-006 reset  input  1  is the asynchronous active-high reset.
REQ-007 start  input  1  is a one-cycle pulse that begins a test run.
REQ-008 req_valid  input  NUM_REQ  gives per-requester data valid.
REQ-009 req_data  input  NUM_REQ*DATA_WIDTH  holds the requester words; requester i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
REQ-010 req_ready  output  NUM_REQ  gives the per-requester accept strobe.
REQ-011 chk_valid, chk_data, chk_src  output  1, DATA_WIDTH, 3  form the registered beat to the shared compare checker: valid, word and source index.
REQ-012 chk_done, chk_error  input  1, 1  carry the checker status.
REQ-013 test_done, test_pass, timeout  output  1, 1, 1  carry the sticky run status.
REQ-014 err_src  output  3  is the source index of the failing beat.

Function
REQ-015 The FSM SHALL have the states IDLE, RUN, DONE and FAIL; there are no other states.
REQ-016 On a start pulse, the FSM SHALL enter RUN from any state except RUN, where start is ignored, and SHALL clear test_done, test_pass, timeout, err_src and the watchdog.
REQ-017 In RUN, the module SHALL perform a round-robin search beginning at rr_ptr and grant the first asserted req_valid; req_ready SHALL be combinational and one-hot on the winner, and all-zero outside RUN or when no req_valid is asserted.
REQ-018 A transfer SHALL occur when req_valid[i] and req_ready[i] are both high; on a transfer, rr_ptr SHALL become (i+1) mod NUM_REQ, otherwise rr_ptr SHALL hold.
REQ-019 Latency: the cycle after a transfer, chk_valid SHALL be 1 and chk_data/chk_src SHALL carry the word and index; otherwise chk_valid SHALL be 0 and chk_data/chk_src SHALL hold.
REQ-020 At most one beat SHALL be forwarded per cycle; no buffering and no beat loss.
REQ-021 In RUN, chk_error=1 SHALL move the FSM to FAIL and latch err_src=chk_src.
REQ-022 In RUN, chk_done=1 with chk_error=0 SHALL move the FSM to DONE.
REQ-023 In RUN, chk_error and chk_done asserted together SHALL resolve to FAIL.
REQ-024 Watchdog: a 16-bit counter SHALL increment on each RUN cycle without a transfer and clear on each transfer.
REQ-025 When the watchdog counter reaches TIMEOUT, the FSM SHALL move to FAIL with timeout=1 and err_src=0.
REQ-026 If chk_error and watchdog expiry coincide, chk_error SHALL take priority and timeout SHALL remain 0.
REQ-027 DONE SHALL drive test_done=1 and test_pass=1; FAIL SHALL drive test_done=1 and test_pass=0; both states SHALL hold until start or reset.
REQ-028 A beat transferred in the RUN cycle in which the FSM exits RUN SHALL still appear on chk_valid the next cycle.

Reset
REQ-029 While reset is high, the module SHALL asynchronously force IDLE, rr_ptr=0, watchdog=0, chk_valid=0, chk_data=0, chk_src=0, test_done=0, test_pass=0, timeout=0 and err_src=0.
REQ-030 Reset asserted mid-RUN SHALL abort the run; any in-flight registered beat is discarded.

Configuration
REQ-031 When STREAM_CHECK_ARBITER_STATS_EN is defined, the module SHALL add output beat_count [31:0], which counts transfers, clears on start and reset, and saturates at 0xFFFFFFFF.
REQ-032 When STREAM_CHECK_ARBITER_STATS_EN is undefined, the beat_count port and its counter SHALL be absent, and all other behaviour SHALL be identical.

Verification
REQ-033 Reset then start with req_valid=4'b1111 held -> grants SHALL follow 0,1,2,3,0; chk_src SHALL follow the same sequence one cycle later, each beat carrying the matching word.
REQ-034 Beat 3 sent from requester 2 and chk_error pulses -> the next cycle SHALL show test_done=1, test_pass=0, err_src=2, timeout=0, and req_ready SHALL be 0 thereafter.
REQ-035 TIMEOUT=8, start, with no req_valid -> FAIL SHALL be entered after 8 idle cycles, with timeout=1 and test_pass=0.
REQ-036 chk_error and chk_done in the same cycle -> FAIL; separately, chk_error coinciding with watchdog expiry -> FAIL with timeout=0.
REQ-037 Reset pulsed mid-RUN after 5 beats -> all outputs SHALL be 0; a subsequent start SHALL begin granting from requester 0.
REQ-038 With STREAM_CHECK_ARBITER_STATS_EN defined, 10 transfers then chk_done -> beat_count=10, test_pass=1; a second start SHALL reset beat_count to 0.

Source files
------------

// File: rtl/stream_check_arbiter_if.sv
// Requester/checker bundle for stream_check_arbiter. The slave modport is the arbiter side.
// The master modport is the environment side, which drives the requesters and the checker status.
interface stream_check_arbiter_if #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REQ    = 4
);
  logic                          start;
  logic [NUM_REQ-1:0]            req_valid;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
  logic [NUM_REQ-1:0]            req_ready;
  logic                          chk_valid;
  logic [DATA_WIDTH-1:0]         chk_data;
  logic [2:0]                    chk_src;
  logic                          chk_done;
  logic                          chk_error;
  logic                          test_done;
  logic                          test_pass;
  logic                          timeout;
  logic [2:0]                    err_src;

  modport master (
    output start, req_valid, req_data, chk_done, chk_error,
    input  req_ready, chk_valid, chk_data, chk_src, test_done, test_pass, timeout, err_src
  );

  modport slave (
    input  start, req_valid, req_data, chk_done, chk_error,
    output req_ready, chk_valid, chk_data, chk_src, test_done, test_pass, timeout, err_src
  );
endinterface

// File: rtl/stream_check_arbiter.sv
// Round-robin arbiter feeding a compare checker: a grant is combinational, the beat is registered one cycle later, and losers stall.
// A run watchdog is included; STREAM_CHECK_ARBITER_STATS_EN adds a saturating beat_count output.
module stream_check_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REQ    = 4,
  parameter int TIMEOUT    = 1024
) (
  input  logic clk,
  input  logic reset,
  stream_check_arbiter_if.slave bus
`ifdef STREAM_CHECK_ARBITER_STATS_EN
  ,
  output logic [31:0] beat_count
`endif
);

  typedef enum logic [1:0] {IDLE, RUN, DONE, FAIL} state_t;

  state_t                state_q, state_d;
  logic [2:0]            rr_ptr_q;
  logic [15:0]           wdog_q, wdog_d;
  logic                  timeout_q, timeout_d;
  logic [2:0]            err_src_q, err_src_d;
  logic                  chk_valid_q;
  logic [DATA_WIDTH-1:0] chk_data_q;
  logic [2:0]            chk_src_q;

  logic [NUM_REQ-1:0]    rot;
  logic [NUM_REQ-1:0]    grant;
  logic [2:0]            gnt_idx;
  logic                  xfer;
  logic [DATA_WIDTH-1:0] gnt_word;

  // Rotate so bit 0 is the requester at rr_ptr; the lowest set bit wins.
  always_comb begin
    rot      = NUM_REQ'({bus.req_valid, bus.req_valid} >> rr_ptr_q);
    xfer     = 1'b0;
    gnt_idx  = '0;
    gnt_word = '0;
    if (state_q == RUN) begin
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
        if (rot[k]) begin
          xfer    = 1'b1;
          gnt_idx = 3'((32'(rr_ptr_q) + k) % NUM_REQ);
        end
      end
    end
    for (int k = 0; k < NUM_REQ; k++) begin
      if (gnt_idx == 3'(k)) gnt_word = bus.req_data[k*DATA_WIDTH +: DATA_WIDTH];
    end
    grant = xfer ? (NUM_REQ'(1) << gnt_idx) : '0;
  end

  always_comb begin
    state_d   = state_q;
    wdog_d    = wdog_q;
    timeout_d = timeout_q;
    err_src_d = err_src_q;
    case (state_q)
      RUN: begin
        wdog_d = xfer ? 16'd0 : wdog_q + 16'd1;
        // Checker error outranks both done and a simultaneous watchdog expiry.
        if (bus.chk_error) begin
          state_d   = FAIL;
          err_src_d = chk_src_q;
        end else if (bus.chk_done) begin
          state_d = DONE;
        end else if (!xfer && wdog_q == 16'(TIMEOUT - 1)) begin
          state_d   = FAIL;
          timeout_d = 1'b1;
          err_src_d = '0;
        end
      end
      default: begin
        if (bus.start) begin
          state_d   = RUN;
          wdog_d    = '0;
          timeout_d = 1'b0;
          err_src_d = '0;
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      rr_ptr_q    <= '0;
      wdog_q      <= '0;
      timeout_q   <= 1'b0;
      err_src_q   <= '0;
      chk_valid_q <= 1'b0;
      chk_data_q  <= '0;
      chk_src_q   <= '0;
    end else begin
      state_q     <= state_d;
      wdog_q      <= wdog_d;
      timeout_q   <= timeout_d;
      err_src_q   <= err_src_d;
      chk_valid_q <= xfer;
      if (xfer) begin
        rr_ptr_q   <= 3'((32'(gnt_idx) + 1) % NUM_REQ);
        chk_data_q <= gnt_word;
        chk_src_q  <= gnt_idx;
      end
    end
  end

`ifdef STREAM_CHECK_ARBITER_STATS_EN
  logic [31:0] beat_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      beat_q <= '0;
    end else if (state_q != RUN && bus.start) begin
      beat_q <= '0;
    end else if (xfer && beat_q != 32'hFFFF_FFFF) begin
      beat_q <= beat_q + 32'd1;
    end
  end

  assign beat_count = beat_q;
`endif

  assign bus.req_ready = grant;
  assign bus.chk_valid = chk_valid_q;
  assign bus.chk_data  = chk_data_q;
  assign bus.chk_src   = chk_src_q;
  assign bus.test_done = (state_q == DONE) || (state_q == FAIL);
  assign bus.test_pass = (state_q == DONE);
  assign bus.timeout   = timeout_q;
  assign bus.err_src   = err_src_q;

endmodule

// File: tb/tb_stream_check_arbiter.sv
// Directed plus randomized bench for stream_check_arbiter against a run-level reference model.
// Inputs change on the falling edge; outputs are compared 1 ns after each edge.
module tb_stream_check_arbiter;
  localparam int DW = 32;
  localparam int N  = 4;
  localparam int TO = 8;

  logic clk;
  logic reset;
`ifdef STREAM_CHECK_ARBITER_STATS_EN
  logic [31:0] beat_count;
`endif

  stream_check_arbiter_if #(.DATA_WIDTH(DW), .NUM_REQ(N)) bus ();

  stream_check_arbiter #(.DATA_WIDTH(DW), .NUM_REQ(N), .TIMEOUT(TO)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
`ifdef STREAM_CHECK_ARBITER_STATS_EN
    ,
    .beat_count (beat_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model: run status and the expected registered beat.
  bit      m_run, m_done, m_pass, m_to, m_cv;
  int      m_ptr, m_err, m_idle, m_csrc;
  longint  m_beats;
  logic [DW-1:0] m_cdat;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_outs();
    check("chk_valid", 64'(bus.chk_valid), 64'(m_cv));
    check("chk_src",   64'(bus.chk_src),   64'(m_csrc));
    check("chk_data",  64'(bus.chk_data),  64'(m_cdat));
    check("test_done", 64'(bus.test_done), 64'(m_done));
    check("test_pass", 64'(bus.test_pass), 64'(m_pass));
    check("timeout",   64'(bus.timeout),   64'(m_to));
    check("err_src",   64'(bus.err_src),   64'(m_err));
`ifdef STREAM_CHECK_ARBITER_STATS_EN
    check("beat_count", 64'(beat_count), 64'(m_beats));
`endif
  endtask

  task automatic model_reset();
    m_run = 0; m_done = 0; m_pass = 0; m_to = 0; m_cv = 0;
    m_ptr = 0; m_err = 0; m_idle = 0; m_csrc = 0; m_beats = 0;
    m_cdat = '0;
  endtask

  // Called at a falling edge with reset held low; returns at the next falling edge.
  task automatic do_reset();
    reset = 1'b1;
    #1;
    model_reset();
    check("rst_req_ready", 64'(bus.req_ready), 64'd0);
    check_outs();
    @(negedge clk);
    reset = 1'b0;
  endtask

  // One clock cycle with the inputs already applied.
  task automatic cycle();
    int g;
    logic [N-1:0] sh;
    logic [N-1:0] exp_rdy;
    logic [DW-1:0] word;
    #1;
    g = -1;
    if (m_run) begin
      for (int k = 0; k < N; k++) begin
        sh = bus.req_valid >> ((m_ptr + k) % N);
        if (g < 0 && sh[0]) g = (m_ptr + k) % N;
      end
    end
    exp_rdy = (g >= 0) ? (N'(1) << g) : '0;
    check("req_ready", 64'(bus.req_ready), 64'(exp_rdy));
    word = (g >= 0) ? DW'(bus.req_data >> (g * DW)) : '0;

    if (!m_run && bus.start) begin
      m_run = 1; m_done = 0; m_pass = 0; m_to = 0; m_err = 0; m_idle = 0; m_beats = 0;
    end else if (m_run) begin
      if (bus.chk_error) begin
        m_run = 0; m_done = 1; m_pass = 0; m_err = m_csrc;
      end else if (bus.chk_done) begin
        m_run = 0; m_done = 1; m_pass = 1;
      end else if (g < 0 && m_idle + 1 >= TO) begin
        m_run = 0; m_done = 1; m_pass = 0; m_to = 1; m_err = 0;
      end
      m_idle = (g >= 0) ? 0 : m_idle + 1;
    end
    if (g >= 0) begin
      m_cv = 1; m_csrc = g; m_cdat = word; m_ptr = (g + 1) % N;
      if (m_beats < 64'hFFFF_FFFF) m_beats++;
    end else begin
      m_cv = 0;
    end

    @(posedge clk);
    #1;
    check_outs();
    @(negedge clk);
  endtask

  task automatic pulse_start();
    bus.start = 1'b1;
    cycle();
    bus.start = 1'b0;
  endtask

  initial begin
    reset         = 1'b1;
    bus.start     = 1'b0;
    bus.req_valid = '0;
    bus.req_data  = '0;
    bus.chk_done  = 1'b0;
    bus.chk_error = 1'b0;
    model_reset();
    @(negedge clk);
    do_reset();

    for (int i = 0; i < N; i++) bus.req_data[i*DW +: DW] = 32'hA000_0000 | i;

    // All requesters valid: grants 0,1,2,3,0 then a clean finish.
    bus.req_valid = 4'hF;
    pulse_start();
    repeat (5) cycle();
    bus.req_valid = '0;
    bus.chk_done  = 1'b1;
    cycle();
    bus.chk_done  = 1'b0;
    check("pass_after_done", 64'(bus.test_pass), 64'd1);

    // Error on the third beat (requester 2).
    do_reset();
    bus.req_valid = 4'hF;
    pulse_start();
    repeat (3) cycle();
    bus.chk_error = 1'b1;
    cycle();
    bus.chk_error = 1'b0;
    check("err_src_is_2", 64'(bus.err_src), 64'd2);
    check("err_no_timeout", 64'(bus.timeout), 64'd0);
    repeat (3) cycle();

    // Watchdog: eight idle RUN cycles.
    bus.req_valid = '0;
    pulse_start();
    repeat (TO - 1) cycle();
    check("wdog_not_yet", 64'(bus.test_done), 64'd0);
    cycle();
    check("wdog_fired", 64'(bus.timeout), 64'd1);
    check("wdog_fail", 64'(bus.test_pass), 64'd0);

    // Error together with done, then error together with expiry.
    pulse_start();
    bus.req_valid = 4'h2;
    cycle();
    bus.req_valid = '0;
    bus.chk_error = 1'b1;
    bus.chk_done  = 1'b1;
    cycle();
    bus.chk_error = 1'b0;
    bus.chk_done  = 1'b0;
    check("err_done_fail", 64'(bus.test_pass), 64'd0);
    pulse_start();
    repeat (TO - 1) cycle();
    bus.chk_error = 1'b1;
    cycle();
    bus.chk_error = 1'b0;
    check("err_beats_wdog", 64'(bus.timeout), 64'd0);
    check("err_beats_wdog_done", 64'(bus.test_done), 64'd1);

    // Reset mid-run after five beats, then restart from requester 0.
    bus.req_valid = 4'hF;
    pulse_start();
    repeat (5) cycle();
    do_reset();
    pulse_start();
    repeat (3) cycle();
    bus.chk_done = 1'b1;
    cycle();
    bus.chk_done = 1'b0;

`ifdef STREAM_CHECK_ARBITER_STATS_EN
    do_reset();
    bus.req_valid = 4'hF;
    pulse_start();
    repeat (10) cycle();
    bus.req_valid = '0;
    bus.chk_done  = 1'b1;
    cycle();
    bus.chk_done  = 1'b0;
    check("beat_count_10", 64'(beat_count), 64'd10);
    check("stats_pass", 64'(bus.test_pass), 64'd1);
    pulse_start();
    check("beat_count_clr", 64'(beat_count), 64'd0);
`endif

    // Randomized runs.
    for (int r = 0; r < 10; r++) begin
      pulse_start();
      for (int c = 0; c < 30; c++) begin
        for (int i = 0; i < N; i++) bus.req_data[i*DW +: DW] = $urandom;
        bus.req_valid = ($urandom_range(0, 5) == 0) ? '0 : N'($urandom);
        bus.chk_error = ($urandom_range(0, 39) == 0);
        bus.chk_done  = ($urandom_range(0, 39) == 0);
        bus.start     = ($urandom_range(0, 14) == 0);
        if ($urandom_range(0, 99) == 0) do_reset();
        else cycle();
      end
      bus.start     = 1'b0;
      bus.chk_error = 1'b0;
      bus.chk_done  = 1'b0;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
